tile_map_writer: RTL and testbench
==================================

# tile_map_writer

Writable tile map that is the write-side counterpart of the read-only tile lookup. It holds the 8×6 playfield of 2-bit tile types and fills it from a serial level stream. It applies single-cell updates from game logic, such as erasing a collected gem or breaking a block, and keeps a live count of gem tiles. The drawing path reads tile types through a registered read port, so a level can change at runtime instead of being fixed at synthesis.

## Interface
- COLS, 8, columns per row (x range 0..COLS-1)
- ROWS, 6, rows (y range 0..ROWS-1)
- GEM, 2'b10, tile type counted by `remaining`
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse; begin loading a full level
- ld_valid  in  1  stream beat valid
- ld_type  in  2  tile type for current load index
- ld_ready  out  1  high while in LOAD
- load_done  out  1  one-cycle pulse after last beat accepted
- wr_req  in  1  single-cell write request (one cycle)
- wr_x, wr_y  in  3 each  target cell
- wr_type  in  2  new tile type
- wr_ack  out  1  one-cycle pulse, write performed
- wr_err  out  1  one-cycle pulse, write rejected (out of range)
- rd_x, rd_y  in  3 each  read address
- rd_type  out  2  registered tile type at (rd_x, rd_y)
- remaining  out  6  number of cells equal to GEM
- all_clear  out  1  one-cycle pulse when a write drops `remaining` to 0
- busy  out  1  high in LOAD

## Operation
- Storage: COLS×ROWS cells of 2 bits, row-major index = y·COLS + x. Reset clears every cell to 2'b00.
- FSM states IDLE, LOAD, READY. Reset enters IDLE.
- IDLE: writes are ignored with no ack and no err. `load_start` moves to LOAD.
- LOAD: index counter starts at 0 and `remaining` is cleared to 0.
  - Each cycle with ld_valid && ld_ready writes ld_type to the cell at index, increments index, and increments `remaining` if ld_type == GEM.
  - The beat at index COLS·ROWS-1 moves the FSM to READY and pulses load_done on the next cycle.
  - A `load_start` in LOAD restarts at index 0 and clears `remaining`. That cycle's beat is discarded.
  - wr_req in LOAD is ignored: no ack, no err.
- READY: a wr_req with x<COLS and y<ROWS writes wr_type to the cell.
  - `remaining` decrements if old==GEM and new!=GEM. It increments if old!=GEM and new==GEM. It is unchanged otherwise.
  - An out-of-range wr_req writes nothing and pulses wr_err.
  - `load_start` moves to LOAD. If wr_req arrives in the same cycle, load wins: the write is dropped with no ack and no err.
- all_clear pulses only for a READY write that moves `remaining` from 1 to 0. It never pulses during LOAD.
- Read port: every edge, rd_type <= cell[rd_y][rd_x], or 2'b00 if the address is out of range. The read port is active in all states.
- Count arithmetic: `remaining` is 6 bits unsigned. It cannot exceed 48 or go below 0 by construction.

## Timing
- Reset values: ld_ready=0, load_done=0, wr_ack=0, wr_err=0, rd_type=0, remaining=0, all_clear=0, busy=0.
- ld_ready and busy are registered state decodes. They go high the cycle after `load_start` is sampled.
- Load latency: 48 accepted beats. load_done is asserted in the first READY cycle.
- Write: the cell and `remaining` update on the edge that samples wr_req. wr_ack or wr_err is high for exactly the following cycle. all_clear is high in the same cycle as wr_ack.
- Read latency is 1 cycle.
  - A read addressed in the same cycle as a write to that cell returns the old value.
  - A read issued one cycle later returns the new value.
- Back-to-back wr_req on consecutive cycles are all accepted and each is acked.
- Reset mid-LOAD aborts immediately to IDLE. All cells and all outputs take their reset values.

## Test plan
- Reset, then load 48 beats: all 00 except row 5 = 01 and cell (3,2) = GEM → load_done pulses once, remaining=1, rd at (3,2) gives 10 one cycle later, rd at (0,5) gives 01.
- In READY, write (3,2)=00 → wr_ack next cycle, remaining 1→0, all_clear pulses with wr_ack, rd (3,2) gives 00.
- wr_req at (7,6) → wr_err pulse, no wr_ack, map and remaining unchanged. Then write (7,5)=GEM → remaining +1, no all_clear.
- load_start after 20 beats, then a gap of ld_valid=0, then 48 beats with 3 GEMs → index restarts at 0, load_done only after the final 48th beat, remaining=3.
- load_start and wr_req in the same READY cycle → no ack, busy=1 next cycle, target cell keeps its pre-load value until overwritten by the stream.
- Assert reset after 10 beats of a load → busy=0, remaining=0, rd_type=00 at every address, ld_ready=0. After reset, a wr_req in IDLE yields no wr_ack and no wr_err.

Source files
------------

// File: rtl/tile_map_writer.sv
// Writable 8x6 tile map: serial level load, single-cell updates from game logic,
// live gem count and a registered read port for the drawing path.
module tile_map_writer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       ld_valid,
  input  logic [1:0] ld_type,
  output logic       ld_ready,
  output logic       load_done,
  input  logic       wr_req,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic [1:0] wr_type,
  output logic       wr_ack,
  output logic       wr_err,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [1:0] rd_type,
  output logic [5:0] remaining,
  output logic       all_clear,
  output logic       busy
);

  localparam int         COLS  = 8;
  localparam int         ROWS  = 6;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [1:0] GEM   = 2'b10;
  localparam logic [5:0] LAST  = 6'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t     state_q, state_d;
  logic [1:0] cell_q [CELLS];
  logic [1:0] cell_d [CELLS];
  logic [5:0] idx_q, idx_d;
  logic [5:0] rem_q, rem_d;
  logic       load_done_q, load_done_d;
  logic       wr_ack_q, wr_ack_d;
  logic       wr_err_q, wr_err_d;
  logic       all_clear_q, all_clear_d;
  logic [1:0] rd_type_q, rd_type_d;

  // With COLS = 8 the row-major index is simply {y, x}.
  logic [5:0] wr_idx, rd_idx;
  logic       wr_in_range, rd_in_range;
  logic [1:0] wr_old;

  assign wr_idx      = {wr_y, wr_x};
  assign rd_idx      = {rd_y, rd_x};
  assign wr_in_range = (wr_y < 3'(ROWS));
  assign rd_in_range = (rd_y < 3'(ROWS));
  assign wr_old      = wr_in_range ? cell_q[wr_idx] : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && ld_valid && idx_q == LAST) state_d = READY;
      READY:   if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CELLS; i++) cell_d[i] = cell_q[i];
    idx_d       = idx_q;
    rem_d       = rem_q;
    load_done_d = 1'b0;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    all_clear_d = 1'b0;
    rd_type_d   = rd_in_range ? cell_q[rd_idx] : 2'b00;
    // load_start outranks both a stream beat and a pending write.
    if (load_start) begin
      idx_d = 6'd0;
      rem_d = 6'd0;
    end else begin
      case (state_q)
        LOAD: if (ld_valid) begin
          cell_d[idx_q] = ld_type;
          idx_d         = idx_q + 6'd1;
          if (ld_type == GEM) rem_d = rem_q + 6'd1;
          if (idx_q == LAST) load_done_d = 1'b1;
        end
        READY: if (wr_req) begin
          if (wr_in_range) begin
            cell_d[wr_idx] = wr_type;
            wr_ack_d       = 1'b1;
            if (wr_old == GEM && wr_type != GEM) begin
              rem_d       = rem_q - 6'd1;
              all_clear_d = (rem_q == 6'd1);
            end else if (wr_old != GEM && wr_type == GEM) begin
              rem_d = rem_q + 6'd1;
            end
          end else begin
            wr_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) cell_q[i] <= 2'b00;
      idx_q       <= 6'd0;
      rem_q       <= 6'd0;
      load_done_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      all_clear_q <= 1'b0;
      rd_type_q   <= 2'b00;
    end else begin
      for (int i = 0; i < CELLS; i++) cell_q[i] <= cell_d[i];
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      load_done_q <= load_done_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      all_clear_q <= all_clear_d;
      rd_type_q   <= rd_type_d;
    end
  end

  assign ld_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign load_done = load_done_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign all_clear = all_clear_q;
  assign rd_type   = rd_type_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Scoreboard bench for tile_map_writer: drivers push expected pulse events and
// read results into queues, a negedge monitor pops and compares them.
module tb_tile_map_writer;

  localparam logic [1:0] GEM = 2'b10;
  localparam int S_IDLE = 0, S_LOAD = 1, S_READY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0, ld_valid = 1'b0;
  logic [1:0] ld_type = 2'b00;
  logic       ld_ready, load_done;
  logic       wr_req = 1'b0;
  logic [2:0] wr_x = 3'd0, wr_y = 3'd0;
  logic [1:0] wr_type = 2'b00;
  logic       wr_ack, wr_err;
  logic [2:0] rd_x = 3'd0, rd_y = 3'd0;
  logic [1:0] rd_type;
  logic [5:0] remaining;
  logic       all_clear, busy;

  tile_map_writer dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
    .ld_type(ld_type), .ld_ready(ld_ready), .load_done(load_done),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_x(rd_x), .rd_y(rd_y),
    .rd_type(rd_type), .remaining(remaining), .all_clear(all_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  // {ack, err, done, all_clear, remaining}
  typedef logic [9:0] ev_t;

  ev_t        ev_q [$];
  logic [1:0] rd_q [$];
  int         n_cmp = 0, n_fail = 0;
  logic       rd_issue = 1'b0, rd_issue_q = 1'b0;

  logic [1:0] mdl [48];
  int         mrem;
  int         mstate;

  always @(posedge clk) rd_issue_q <= rd_issue;

  always @(negedge clk) begin
    ev_t got, exp;
    logic [1:0] rexp;
    if (!reset) begin
      if (wr_ack || wr_err || load_done || all_clear) begin
        got = {wr_ack, wr_err, load_done, all_clear, remaining};
        n_cmp++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected got=%b exp=none", got);
        end else begin
          exp = ev_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL event got=%b exp=%b (ack,err,done,clr,rem)", got, exp);
          end
        end
      end
      if (rd_issue_q) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL read_no_expect got=%b exp=none", rd_type);
        end else begin
          rexp = rd_q.pop_front();
          if (rd_type !== rexp) begin
            n_fail++;
            $display("FAIL read got=%b exp=%b", rd_type, rexp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [1:0] lvl_type(input int lvl, input int i);
    case (lvl)
      0: return (i == 19) ? GEM : ((i >= 40) ? 2'b01 : 2'b00);
      1: return GEM;
      2: begin
        if (i == 0 || i == 24 || i == 47) return GEM;
        if (i % 3 == 1) return 2'b01;
        if (i % 5 == 0) return 2'b11;
        return 2'b00;
      end
      default: return (i == 10 || i == 30) ? GEM : 2'b11;
    endcase
  endfunction

  task automatic do_read(input int x, input int y);
    rd_x = 3'(x); rd_y = 3'(y); rd_issue = 1'b1;
    rd_q.push_back((y < 6) ? mdl[y*8+x] : 2'b00);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic do_write(input int x, input int y, input logic [1:0] t, input bit also_rd);
    int idx, nrem;
    logic [1:0] old;
    wr_req = 1'b1; wr_x = 3'(x); wr_y = 3'(y); wr_type = t;
    if (also_rd) begin
      rd_x = 3'(x); rd_y = 3'(y); rd_issue = 1'b1;
      rd_q.push_back((y < 6) ? mdl[y*8+x] : 2'b00);
    end
    if (mstate == S_READY) begin
      if (y < 6) begin
        idx = y*8 + x;
        old = mdl[idx];
        nrem = mrem;
        if (old == GEM && t != GEM) nrem = mrem - 1;
        else if (old != GEM && t == GEM) nrem = mrem + 1;
        ev_q.push_back({1'b1, 1'b0, 1'b0, (mrem == 1 && nrem == 0), 6'(nrem)});
        mrem = nrem;
        mdl[idx] = t;
      end else begin
        ev_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 6'(mrem)});
      end
    end
    @(negedge clk);
    wr_req = 1'b0;
    rd_issue = 1'b0;
  endtask

  task automatic start_load(input bit beat_too, input bit wr_too);
    load_start = 1'b1;
    if (beat_too) begin ld_valid = 1'b1; ld_type = GEM; end
    if (wr_too) begin wr_req = 1'b1; wr_x = 3'd3; wr_y = 3'd2; wr_type = GEM; end
    mstate = S_LOAD;
    mrem = 0;
    @(negedge clk);
    load_start = 1'b0; ld_valid = 1'b0; wr_req = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ld_ready_after_start", ld_ready, 1);
  endtask

  task automatic beats(input int lvl, input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_type = lvl_type(lvl, i);
      mdl[i] = ld_type;
      if (ld_type == GEM) mrem++;
      if (i == 47) begin
        mstate = S_READY;
        ev_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 6'(mrem)});
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 48; i++) mdl[i] = 2'b00;
    mrem = 0;
    mstate = S_IDLE;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_rd_type", rd_type, 0);
    chk("rst_pulses", {load_done, wr_ack, wr_err, all_clear}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Level A: row 5 = 01, (3,2) = GEM
    start_load(1'b0, 1'b0);
    beats(0, 48);
    chk("lvlA_remaining", remaining, 1);
    chk("lvlA_busy", busy, 0);
    do_read(3, 2);
    do_read(0, 5);

    // Erase the only gem, read same cycle (old) and next cycle (new)
    do_write(3, 2, 2'b00, 1'b1);
    do_read(3, 2);
    chk("erase_remaining", remaining, 0);

    do_write(7, 6, GEM, 1'b0);
    do_read(7, 5);
    do_read(7, 6);
    do_write(7, 5, GEM, 1'b0);
    chk("gem_add_remaining", remaining, 1);

    // Back-to-back writes ending in a second all_clear
    do_write(0, 0, GEM, 1'b0);
    do_write(1, 0, GEM, 1'b0);
    do_write(0, 0, 2'b01, 1'b0);
    do_write(1, 0, 2'b00, 1'b0);
    do_write(7, 5, 2'b11, 1'b0);
    chk("b2b_remaining", remaining, 0);
    do_read(7, 5);
    do_read(0, 0);

    // Partial load, restart with a discarded beat, gap, then level B
    start_load(1'b0, 1'b0);
    beats(1, 20);
    chk("partial_remaining", remaining, 20);
    chk("partial_no_done_busy", busy, 1);
    start_load(1'b1, 1'b0);
    chk("restart_remaining", remaining, 0);
    repeat (3) @(negedge clk);
    chk("gap_remaining", remaining, 0);
    beats(2, 48);
    chk("lvlB_remaining", remaining, 3);
    do_read(0, 0);
    do_read(3, 2);
    do_read(0, 3);
    do_read(7, 5);

    // load_start and wr_req together: load wins, cell keeps its old value
    start_load(1'b0, 1'b1);
    do_read(3, 2);
    beats(3, 48);
    chk("lvlC_remaining", remaining, 2);
    do_read(3, 2);
    do_read(2, 1);

    // Reset in the middle of a load
    start_load(1'b0, 1'b0);
    beats(3, 10);
    reset = 1'b1;
    #1;
    chk("midrst_busy_async", busy, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    chk("midrst_remaining", remaining, 0);
    for (int i = 0; i < 48; i++) do_read(i % 8, i / 8);
    do_write(3, 2, GEM, 1'b0);
    chk("idle_wr_ack", wr_ack, 0);
    chk("idle_wr_err", wr_err, 0);
    repeat (3) @(negedge clk);
    do_read(3, 2);
    repeat (2) @(negedge clk);

    n_cmp++;
    if (ev_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect got=%0d exp=0", ev_q.size() + rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
